// File: rtl/stall_pkg.sv
// Shared types and helpers for the parametrised pipeline stall controller.
package stall_pkg;

    localparam int MAX_STAGES = 64;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_LD,
        HOLD_ST,
        HOLD_BR
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BR,
        SRC_LD,
        SRC_ST
    } src_e;

    // Vector with the low `depth` bits set; callers slice it to their stage count.
    function automatic logic [MAX_STAGES-1:0] depth_mask(input int depth);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < depth) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Branch beats load beats store.
    function automatic src_e pick_source(input logic br, input logic ld, input logic st);
        if (br)      return SRC_BR;
        else if (ld) return SRC_LD;
        else if (st) return SRC_ST;
        else         return SRC_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stall_ctrl_gen.sv
// Pipeline stall controller: prioritised per-source masks, multi-cycle hold FSM,
// level-held external freeze and a saturating stall-cycle counter.
module stall_ctrl_gen
    import stall_pkg::*;
#(
    parameter int NUM_STAGES    = 6,
    parameter int LOAD_DEPTH    = 3,
    parameter int STORE_DEPTH   = 3,
    parameter int BRANCH_STAGE  = 1,
    parameter int LOAD_CYCLES   = 1,
    parameter int STORE_CYCLES  = 1,
    parameter int BRANCH_CYCLES = 1,
    parameter int PERF_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_load_i,
    input  logic                  stall_store_i,
    input  logic                  stall_branch_i,
    input  logic                  stall_ext_i,
    input  logic                  perf_clr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  hold_busy_o,
    output logic [PERF_W-1:0]     perf_cnt_o
);

    if (LOAD_CYCLES < 1 || STORE_CYCLES < 1 || BRANCH_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "stall_ctrl_gen: every *_CYCLES parameter must be >= 1");
    end
    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "stall_ctrl_gen: NUM_STAGES out of range");
    end
    if (LOAD_DEPTH < 1 || LOAD_DEPTH > NUM_STAGES || STORE_DEPTH < 1 || STORE_DEPTH > NUM_STAGES) begin : g_bad_depth
        $fatal(1, "stall_ctrl_gen: LOAD_DEPTH/STORE_DEPTH out of range");
    end
    if (BRANCH_STAGE < 0 || BRANCH_STAGE >= NUM_STAGES) begin : g_bad_branch
        $fatal(1, "stall_ctrl_gen: BRANCH_STAGE out of range");
    end

    localparam int MAX_CYC = (LOAD_CYCLES > STORE_CYCLES)
                           ? ((LOAD_CYCLES > BRANCH_CYCLES) ? LOAD_CYCLES : BRANCH_CYCLES)
                           : ((STORE_CYCLES > BRANCH_CYCLES) ? STORE_CYCLES : BRANCH_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [NUM_STAGES-1:0] LOAD_MASK  = NUM_STAGES'(depth_mask(LOAD_DEPTH));
    localparam logic [NUM_STAGES-1:0] STORE_MASK = NUM_STAGES'(depth_mask(STORE_DEPTH));
    localparam logic [NUM_STAGES-1:0] BR_MASK    = NUM_STAGES'(1) << BRANCH_STAGE;
    localparam logic [NUM_STAGES-1:0] EXT_MASK   = {NUM_STAGES{1'b1}};

    // The entry cycle is already one stall cycle, so the hold counts down from CYCLES-2.
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'((LOAD_CYCLES   > 1) ? LOAD_CYCLES   - 2 : 0);
    localparam logic [CNT_W-1:0] ST_INIT = CNT_W'((STORE_CYCLES  > 1) ? STORE_CYCLES  - 2 : 0);
    localparam logic [CNT_W-1:0] BR_INIT = CNT_W'((BRANCH_CYCLES > 1) ? BRANCH_CYCLES - 2 : 0);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] base_mask;
    logic                  busy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_mask = '0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (pick_source(stall_branch_i, stall_load_i, stall_store_i))
                    SRC_BR: begin
                        base_mask = BR_MASK;
                        if (BRANCH_CYCLES > 1) begin
                            state_d = HOLD_BR;
                            cnt_d   = BR_INIT;
                        end
                    end
                    SRC_LD: begin
                        base_mask = LOAD_MASK;
                        if (LOAD_CYCLES > 1) begin
                            state_d = HOLD_LD;
                            cnt_d   = LD_INIT;
                        end
                    end
                    SRC_ST: begin
                        base_mask = STORE_MASK;
                        if (STORE_CYCLES > 1) begin
                            state_d = HOLD_ST;
                            cnt_d   = ST_INIT;
                        end
                    end
                    default: base_mask = '0;
                endcase
            end
            HOLD_LD, HOLD_ST, HOLD_BR: begin
                busy = 1'b1;
                if (state_q == HOLD_LD)      base_mask = LOAD_MASK;
                else if (state_q == HOLD_ST) base_mask = STORE_MASK;
                else                         base_mask = BR_MASK;
                // New hazard requests are deliberately ignored while holding.
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the vector directly so the pipeline is released the moment rst_n falls.
    assign stall_o     = rst_n ? (base_mask | (stall_ext_i ? EXT_MASK : '0)) : '0;
    assign hold_busy_o = busy;

    sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (perf_clr_i),
        .inc_i (|stall_o),
        .cnt_o (perf_cnt_o)
    );

endmodule

// File: tb/tb_stall_ctrl_gen.sv
// Three differently parametrised controllers on shared stimulus, each checked every
// cycle against a remaining-cycles model, plus directed literal expectations.
module tb_stall_ctrl_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld = 1'b0, st = 1'b0, br = 1'b0, ext = 1'b0, clr = 1'b0;

    logic [5:0]  stall_a, stall_b;
    logic [7:0]  stall_c;
    logic        busy_a, busy_b, busy_c;
    logic [3:0]  perf_a;
    logic [31:0] perf_b;
    logic [7:0]  perf_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: defaults with 4-bit perf counter.
    stall_ctrl_gen #(.PERF_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_load_i(ld), .stall_store_i(st),
        .stall_branch_i(br), .stall_ext_i(ext), .perf_clr_i(clr),
        .stall_o(stall_a), .hold_busy_o(busy_a), .perf_cnt_o(perf_a));

    // B: multi-cycle load/store/branch holds.
    stall_ctrl_gen #(.LOAD_CYCLES(3), .STORE_CYCLES(2), .BRANCH_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_load_i(ld), .stall_store_i(st),
        .stall_branch_i(br), .stall_ext_i(ext), .perf_clr_i(clr),
        .stall_o(stall_b), .hold_busy_o(busy_b), .perf_cnt_o(perf_b));

    // C: wider pipe, odd masks, long load hold.
    stall_ctrl_gen #(.NUM_STAGES(8), .LOAD_DEPTH(4), .STORE_DEPTH(8), .BRANCH_STAGE(5),
                     .LOAD_CYCLES(5), .STORE_CYCLES(1), .BRANCH_CYCLES(2), .PERF_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall_load_i(ld), .stall_store_i(st),
        .stall_branch_i(br), .stall_ext_i(ext), .perf_clr_i(clr),
        .stall_o(stall_c), .hold_busy_o(busy_c), .perf_cnt_o(perf_c));

    // Model configuration, one entry per DUT.
    int cfg_nst[3] = '{6, 6, 8};
    int cfg_ldd[3] = '{3, 3, 4};
    int cfg_std[3] = '{3, 3, 8};
    int cfg_brs[3] = '{1, 1, 5};
    int cfg_ldc[3] = '{1, 3, 5};
    int cfg_stc[3] = '{1, 2, 1};
    int cfg_brc[3] = '{1, 4, 2};
    int cfg_pw[3]  = '{4, 32, 8};

    // Model state: stall cycles still owed by the current hold, its mask, perf count.
    int      m_rem[3]  = '{0, 0, 0};
    longint  m_mask[3] = '{0, 0, 0};
    longint  m_perf[3] = '{0, 0, 0};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        longint act_s[3], act_p[3];
        logic   act_b[3];
        act_s = '{longint'(stall_a), longint'(stall_b), longint'(stall_c)};
        act_p = '{longint'(perf_a), longint'(perf_b), longint'(perf_c)};
        act_b = '{busy_a, busy_b, busy_c};
        for (int k = 0; k < 3; k++) begin
            longint all_ones, base, exp_s, pmax;
            int     nrem;
            logic   exp_b;
            all_ones = (longint'(1) << cfg_nst[k]) - 1;
            pmax     = (longint'(1) << cfg_pw[k]) - 1;
            if (!rst_n) begin
                m_rem[k]  = 0;
                m_perf[k] = 0;
                check($sformatf("rst_stall[%0d]", k), act_s[k], 0);
                check($sformatf("rst_busy[%0d]", k), longint'(act_b[k]), 0);
                check($sformatf("rst_perf[%0d]", k), act_p[k], 0);
            end else begin
                exp_b = (m_rem[k] > 0);
                if (m_rem[k] > 0) begin
                    base = m_mask[k];
                    nrem = m_rem[k] - 1;
                end else if (br) begin
                    base = longint'(1) << cfg_brs[k];
                    nrem = cfg_brc[k] - 1;
                end else if (ld) begin
                    base = (longint'(1) << cfg_ldd[k]) - 1;
                    nrem = cfg_ldc[k] - 1;
                end else if (st) begin
                    base = (longint'(1) << cfg_std[k]) - 1;
                    nrem = cfg_stc[k] - 1;
                end else begin
                    base = 0;
                    nrem = 0;
                end
                exp_s = base | (ext ? all_ones : 0);
                check($sformatf("stall[%0d]", k), act_s[k], exp_s);
                check($sformatf("busy[%0d]", k), longint'(act_b[k]), longint'(exp_b));
                check($sformatf("perf[%0d]", k), act_p[k], m_perf[k]);
                m_rem[k]  = nrem;
                m_mask[k] = base;
                if (clr)                                    m_perf[k] = 0;
                else if (exp_s != 0 && m_perf[k] < pmax)    m_perf[k] = m_perf[k] + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ld = 0; st = 0; br = 0; ext = 0; clr = 0;
        repeat (n) cyc();
    endtask

    initial begin
        // Reset state.
        repeat (3) cyc();
        #1;
        check("reset stall_a", longint'(stall_a), 0);
        check("reset busy_b", longint'(busy_b), 0);
        check("reset perf_b", longint'(perf_b), 0);
        rst_n = 1'b1;
        idle(2);

        // Single load pulse: A one cycle, B three cycles with busy on the last two.
        ld = 1; #1;
        check("ld t stall_a", longint'(stall_a), 6'b000111);
        check("ld t stall_b", longint'(stall_b), 6'b000111);
        check("ld t busy_b", longint'(busy_b), 0);
        cyc(); ld = 0; #1;
        check("ld t+1 stall_a", longint'(stall_a), 0);
        check("ld t+1 busy_a", longint'(busy_a), 0);
        check("ld t+1 stall_b", longint'(stall_b), 6'b000111);
        check("ld t+1 busy_b", longint'(busy_b), 1);
        cyc(); #1;
        check("ld t+2 stall_b", longint'(stall_b), 6'b000111);
        check("ld t+2 busy_b", longint'(busy_b), 1);
        cyc(); #1;
        check("ld t+3 stall_b", longint'(stall_b), 0);
        check("ld t+3 busy_b", longint'(busy_b), 0);
        idle(6);

        // All three together: branch wins; ext on top gives all ones.
        br = 1; ld = 1; st = 1; #1;
        check("all3 stall_a", longint'(stall_a), 6'b000010);
        check("all3 stall_c", longint'(stall_c), 8'b0010_0000);
        cyc(); ext = 1; #1;
        check("all3+ext stall_a", longint'(stall_a), 6'b111111);
        idle(8);

        // B: branch hold of 4 swallows a load pulse arriving at t+1.
        br = 1; #1;
        check("br t stall_b", longint'(stall_b), 6'b000010);
        cyc(); br = 0; ld = 1; #1;
        check("br t+1 stall_b", longint'(stall_b), 6'b000010);
        cyc(); ld = 0; #1;
        check("br t+2 stall_b", longint'(stall_b), 6'b000010);
        cyc(); #1;
        check("br t+3 stall_b", longint'(stall_b), 6'b000010);
        cyc(); #1;
        check("br t+4 stall_b", longint'(stall_b), 0);
        check("br t+4 busy_b", longint'(busy_b), 0);
        idle(6);

        // C: reset two cycles into a five-cycle load hold.
        ld = 1; cyc(); ld = 0; cyc();
        #1;
        check("c hold busy", longint'(busy_c), 1);
        rst_n = 1'b0; #1;
        check("c rst stall", longint'(stall_c), 0);
        check("c rst busy", longint'(busy_c), 0);
        cyc(); cyc(); rst_n = 1'b1;
        idle(2); #1;
        check("c post-rst stall", longint'(stall_c), 0);
        check("c post-rst busy", longint'(busy_c), 0);
        idle(2);

        // A: 4-bit perf counter saturates under a 20-cycle freeze, then clears.
        ext = 1;
        repeat (19) cyc();
        #1;
        check("perf_a sat", longint'(perf_a), 15);
        cyc(); clr = 1; #1;
        check("perf_a pre-clr", longint'(perf_a), 15);
        cyc(); clr = 0; #1;
        check("perf_a cleared", longint'(perf_a), 0);
        cyc(); #1;
        check("perf_a resume", longint'(perf_a), 1);
        idle(6);

        // Randomised traffic, with rare resets and perf clears.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ld    = ($urandom_range(0, 3) == 0);
            st    = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 5) == 0);
            ext   = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 40) == 0);
            rst_n = ($urandom_range(0, 250) != 0);
        end
        rst_n = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl_gen.md
Name: stall_ctrl_gen

Overview:
Parametrised pipeline stall controller. It replaces the fixed 6-stage, single-cycle stall decoder. Per-source stall masks are generalised to N stages. Load, store and branch stalls can last a configurable number of cycles, sequenced by a hold FSM and counter. It also adds an external level-held freeze request (multicycle unit) and a saturating stall-cycle performance counter. It sits between the hazard-detection logic and the pipeline registers; stall bit i holds stage i.

Parameters:
NUM_STAGES, 6, number of pipeline stages; width of the stall vector.
LOAD_DEPTH, 3, load stall holds stages [LOAD_DEPTH-1:0]; range 1..NUM_STAGES.
STORE_DEPTH, 3, store stall holds stages [STORE_DEPTH-1:0]; range 1..NUM_STAGES.
BRANCH_STAGE, 1, single stage held on a branch stall; range 0..NUM_STAGES-1.
LOAD_CYCLES, 1, load stall duration in cycles; minimum 1.
STORE_CYCLES, 1, store stall duration in cycles; minimum 1.
BRANCH_CYCLES, 1, branch stall duration in cycles; minimum 1.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_load_i  in  1  load-use hazard request, single-cycle pulse or level
stall_store_i  in  1  store hazard request
stall_branch_i  in  1  branch hazard request
stall_ext_i  in  1  external freeze (multicycle unit busy), level-held
perf_clr_i  in  1  synchronous clear of the perf counter
stall_o  out  NUM_STAGES  per-stage hold vector
hold_busy_o  out  1  FSM is in a multi-cycle hold
perf_cnt_o  out  PERF_W  count of cycles with stall_o != 0

Behaviour:
- Masks are fixed by parameters:
  - LOAD_MASK = (1<<LOAD_DEPTH)-1
  - STORE_MASK = (1<<STORE_DEPTH)-1
  - BR_MASK = 1<<BRANCH_STAGE
  - EXT_MASK = all ones
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0, perf_cnt_o = 0, hold_busy_o = 0.
  - stall_o is forced to 0 combinationally while rst_n is low.
- FSM states: IDLE, HOLD_LD, HOLD_ST, HOLD_BR.
- IDLE:
  - stall_o is combinational from the requests, zero latency.
  - Source priority: branch > load > store. Only the winner's mask is used.
  - If the winner's CYCLES > 1, then on the next edge go to HOLD_x with cnt = CYCLES-2.
  - If CYCLES == 1, stay in IDLE. With all defaults the block is cycle-equivalent to a pure combinational decoder.
- HOLD_x:
  - stall_o = x mask; hold_busy_o = 1.
  - Each cycle: if cnt == 0, go to IDLE; else cnt decrements.
  - Total stall length from the first request cycle is exactly CYCLES.
- Requests during a hold: load, store and branch requests arriving in HOLD_x are ignored and not queued.
  - A requester still asserting after the hold ends is re-evaluated in the first IDLE cycle, which starts a new stall.
- External freeze: stall_ext_i ORs EXT_MASK into stall_o in every state, with zero latency.
  - The hold counter keeps counting during a freeze; the freeze does not extend the hold.
- Simultaneous requests: all three at once in IDLE means branch wins and gives BR_MASK. Ext is always ORed on top.
- Perf counter:
  - perf_clr_i has priority: next value is 0.
  - Otherwise, if stall_o != 0, increment, saturating at 2^PERF_W-1.
- Reset mid-hold: the hold is aborted immediately. After reset release the FSM is in IDLE and no residual stall is issued.
- Counter width is $clog2(max(LOAD_CYCLES, STORE_CYCLES, BRANCH_CYCLES)), minimum 1.
- Elaboration-time checks: any *_CYCLES < 1, a depth out of range, or BRANCH_STAGE >= NUM_STAGES is a fatal error.

Decomposition:
- Shared package stall_pkg holds:
  - state enum {IDLE, HOLD_LD, HOLD_ST, HOLD_BR}
  - a mask-build function (depth -> vector)
  - the source-priority encoding
- One natural sub-module: sat_counter (parametrised width, clear, increment, saturate), used for perf_cnt_o.
- The FSM and counter stay in the top module.

Test Plan:
- Defaults, one-cycle stall_load_i pulse: stall_o=000111 in that cycle only, 0 the next; hold_busy_o stays 0.
- LOAD_CYCLES=3, one-cycle load pulse at cycle t: stall_o=000111 for t, t+1, t+2, 0 at t+3; hold_busy_o=1 at t+1 and t+2 only.
- Defaults, branch+load+store asserted together: stall_o=000010; same with stall_ext_i=1: stall_o=111111.
- BRANCH_CYCLES=4, branch at t, load pulse at t+1: stall_o=000010 for t..t+3; load ignored and stall_o=0 at t+4.
- LOAD_CYCLES=5, rst_n pulled low at t+2 of a hold: stall_o=0 immediately. After release, state is IDLE and there is no stall with requests low.
- PERF_W=4, stall_ext_i held 20 cycles: perf_cnt_o saturates at 15; perf_clr_i for one cycle gives 0 on the next edge, then counting resumes.
